// File: rtl/ecc_ctrl_pkg.sv
// Shared constants, status codes, FSM states and the parity-check matrix
// for the syndrome check controller.
package ecc_ctrl_pkg;

   localparam int unsigned CW_W   = 80;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned SYN_W  = 16;

   // Result status carried alongside every output word.
   typedef enum logic [1:0] {
      ST_CLEAN   = 2'b00,
      ST_CE      = 2'b01,
      ST_DUE     = 2'b10,
      ST_TIMEOUT = 2'b11
   } status_e;

   // Controller FSM; StRun is the all-zero reset state.
   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StDecWait = 2'b01,
      StHold    = 2'b10
   } state_e;

   // Parity-check column for data bit idx: {v, ~v} with v = idx + 1, so every
   // column is nonzero and distinct and any single-bit flip gives a nonzero syndrome.
   function automatic logic [SYN_W-1:0] h_column(input int unsigned idx);
      logic [7:0] v;
      v = 8'(idx + 1);
      return {v, ~v};
   endfunction

endpackage

// File: rtl/syndrome_check.sv
// Combinational syndrome check: recomputes parity over the 64-bit payload and
// XORs it with the received parity; any nonzero syndrome raises error_flag.
module syndrome_check
   import ecc_ctrl_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   output logic [SYN_W-1:0] syndrome,
   output logic             error_flag
);

   logic [DATA_W-1:0] data_shift;

   // Fold the column of every set data bit into the received parity.
   always_comb begin
      syndrome   = codeword[CW_W-1:DATA_W];
      data_shift = codeword[DATA_W-1:0];
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (data_shift[0]) begin
            syndrome = syndrome ^ h_column(i);
         end
         data_shift = data_shift >> 1;
      end
   end

   assign error_flag = |syndrome;

endmodule

// File: rtl/syndrome_check_ctrl.sv
// Streaming wrapper around syndrome_check. Clean codewords flow through a
// two-stage pipeline (chk_reg -> out_reg); an errored codeword stalls the
// stream and is handed to the external correction decoder over req/ack.
module syndrome_check_ctrl
   import ecc_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEC_TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_codeword,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_status,
   output logic              dec_req,
   output logic [CW_W-1:0]   dec_codeword,
   output logic [SYN_W-1:0]  dec_syndrome,
   input  logic              dec_ack,
   input  logic              dec_uncorr,
   input  logic [DATA_W-1:0] dec_data,
   input  logic              clr_counters,
   output logic [CNT_W-1:0]  ce_count,
   output logic [CNT_W-1:0]  due_count
);

   localparam int unsigned      TimerW    = 8;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(DEC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CntMax    = '1;

   state_e            state_q, state_d;
   logic              chk_valid_q, chk_valid_d;
   logic [CW_W-1:0]   chk_cw_q, chk_cw_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   status_e           out_status_q, out_status_d;
   logic              dec_req_q, dec_req_d;
   logic [CW_W-1:0]   dec_cw_q, dec_cw_d;
   logic [SYN_W-1:0]  dec_syn_q, dec_syn_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   status_e           hold_status_q, hold_status_d;
   logic [CNT_W-1:0]  ce_q, ce_d, due_q, due_d;

   logic [SYN_W-1:0]  syndrome;
   logic              error_flag;
   logic              out_free;
   logic              out_fire;
   logic              in_fire;

   syndrome_check u_syndrome_check (
      .codeword   (chk_cw_q),
      .syndrome   (syndrome),
      .error_flag (error_flag)
   );

   // out_reg can take a new word when empty or when it drains this cycle.
   assign out_fire = out_valid_q & out_ready;
   assign out_free = ~out_valid_q | out_ready;
   assign in_ready = ~rst & (state_q == StRun) & (~chk_valid_q | (~error_flag & out_free));
   assign in_fire  = in_valid & in_ready;

   // FSM next state plus pipeline and decoder-interface next values.
   always_comb begin
      state_d       = state_q;
      chk_valid_d   = chk_valid_q;
      chk_cw_d      = chk_cw_q;
      out_valid_d   = out_valid_q & ~out_ready;
      out_data_d    = out_data_q;
      out_status_d  = out_status_q;
      dec_req_d     = dec_req_q;
      dec_cw_d      = dec_cw_q;
      dec_syn_d     = dec_syn_q;
      timer_d       = timer_q;
      hold_data_d   = hold_data_q;
      hold_status_d = hold_status_q;
      unique case (state_q)
         StRun: begin
            if (chk_valid_q && error_flag) begin
               // Errored word stays parked in chk_reg until the result is issued.
               dec_cw_d  = chk_cw_q;
               dec_syn_d = syndrome;
               dec_req_d = 1'b1;
               timer_d   = '0;
               state_d   = StDecWait;
            end else begin
               if (chk_valid_q && out_free) begin
                  out_valid_d  = 1'b1;
                  out_data_d   = chk_cw_q[DATA_W-1:0];
                  out_status_d = ST_CLEAN;
                  chk_valid_d  = 1'b0;
               end
               if (in_fire) begin
                  chk_valid_d = 1'b1;
                  chk_cw_d    = in_codeword;
               end
            end
         end
         StDecWait: begin
            timer_d = timer_q + TimerW'(1);
            // Ack is tested first so it wins over a same-cycle timeout.
            if (dec_ack) begin
               hold_data_d   = dec_data;
               hold_status_d = dec_uncorr ? ST_DUE : ST_CE;
               dec_req_d     = 1'b0;
               state_d       = StHold;
            end else if (timer_q == TimerLast) begin
               hold_data_d   = dec_cw_q[DATA_W-1:0];
               hold_status_d = ST_TIMEOUT;
               dec_req_d     = 1'b0;
               state_d       = StHold;
            end
         end
         StHold: begin
            if (out_free) begin
               out_valid_d  = 1'b1;
               out_data_d   = hold_data_q;
               out_status_d = hold_status_q;
               chk_valid_d  = 1'b0;
               state_d      = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Saturating statistics, counted on the output handshake; clear has priority.
   always_comb begin
      ce_d  = ce_q;
      due_d = due_q;
      if (out_fire) begin
         if (out_status_q == ST_CE && ce_q != CntMax) begin
            ce_d = ce_q + CNT_W'(1);
         end
         if ((out_status_q == ST_DUE || out_status_q == ST_TIMEOUT) && due_q != CntMax) begin
            due_d = due_q + CNT_W'(1);
         end
      end
      if (clr_counters) begin
         ce_d  = '0;
         due_d = '0;
      end
   end

   // State registers with synchronous reset; a reset mid-decode drops the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         chk_valid_q   <= 1'b0;
         chk_cw_q      <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_status_q  <= ST_CLEAN;
         dec_req_q     <= 1'b0;
         dec_cw_q      <= '0;
         dec_syn_q     <= '0;
         timer_q       <= '0;
         hold_data_q   <= '0;
         hold_status_q <= ST_CLEAN;
         ce_q          <= '0;
         due_q         <= '0;
      end else begin
         state_q       <= state_d;
         chk_valid_q   <= chk_valid_d;
         chk_cw_q      <= chk_cw_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_status_q  <= out_status_d;
         dec_req_q     <= dec_req_d;
         dec_cw_q      <= dec_cw_d;
         dec_syn_q     <= dec_syn_d;
         timer_q       <= timer_d;
         hold_data_q   <= hold_data_d;
         hold_status_q <= hold_status_d;
         ce_q          <= ce_d;
         due_q         <= due_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_status   = out_status_q;
   assign dec_req      = dec_req_q;
   assign dec_codeword = dec_cw_q;
   assign dec_syndrome = dec_syn_q;
   assign ce_count     = ce_q;
   assign due_count    = due_q;

endmodule

// File: tb/tb_syndrome_check_ctrl.sv
// Bench for syndrome_check_ctrl: directed and random codewords, a decoder model
// answering dec_req, and a queue-based scoreboard checking every output.
module tb_syndrome_check_ctrl;

   localparam int CNT_W       = 4;
   localparam int DEC_TIMEOUT = 32;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  status;
   } exp_t;

   // kind: 0 = ack after dly cycles, 1 = never ack (timeout), 2 = request is aborted by rst
   typedef struct {
      logic [79:0] cw;
      logic [15:0] syn;
      int          kind;
      int          dly;
      logic        unc;
      logic [63:0] dd;
   } plan_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [79:0]      in_codeword = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [63:0]      out_data;
   logic [1:0]       out_status;
   logic             dec_req;
   logic [79:0]      dec_codeword;
   logic [15:0]      dec_syndrome;
   logic             dec_ack = 1'b0;
   logic             dec_uncorr = 1'b0;
   logic [63:0]      dec_data = '0;
   logic             clr_counters = 1'b0;
   logic [CNT_W-1:0] ce_count;
   logic [CNT_W-1:0] due_count;

   exp_t  exp_q[$];
   plan_t pln_q[$];
   int    fire_cycles[$];
   int    tests = 0;
   int    fails = 0;
   int    accepted = 0;
   int    fired = 0;
   int    cyc = 0;
   int    m_ce = 0;
   int    m_due = 0;
   int    rdy_mode = 0;

   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic [1:0]  prev_status = '0;
   exp_t        mon_e;
   int          outst;

   syndrome_check_ctrl #(
      .CNT_W       (CNT_W),
      .DEC_TIMEOUT (DEC_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_codeword  (in_codeword),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_status   (out_status),
      .dec_req      (dec_req),
      .dec_codeword (dec_codeword),
      .dec_syndrome (dec_syndrome),
      .dec_ack      (dec_ack),
      .dec_uncorr   (dec_uncorr),
      .dec_data     (dec_data),
      .clr_counters (clr_counters),
      .ce_count     (ce_count),
      .due_count    (due_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference syndrome: received parity XOR the parity columns of set data bits,
   // where data bit i contributes v*256 + (255 - v) with v = i + 1.
   function automatic logic [15:0] model_syn(input logic [79:0] cw);
      int          acc;
      logic [63:0] d;
      acc = 32'(cw[79:64]);
      d   = cw[63:0];
      for (int i = 0; i < 64; i++) begin
         if (d[0]) acc = acc ^ ((i + 1) * 256 + (255 - (i + 1)));
         d = d >> 1;
      end
      return 16'(acc);
   endfunction

   function automatic logic [79:0] clean_cw(input logic [63:0] d);
      return {model_syn({16'h0, d}), d};
   endfunction

   // Present one codeword, wait (bounded) for acceptance, then queue its expectation.
   task automatic send(input logic [79:0] cw, input int kind, input int dly, input logic unc,
                       input logic [63:0] dd, output int waits);
      plan_t       p;
      exp_t        e;
      logic [15:0] s;
      bit          ok;
      int          n;
      s           = model_syn(cw);
      in_valid    = 1'b1;
      in_codeword = cw;
      ok          = 1'b0;
      waits       = 0;
      n           = 0;
      while (!ok && n < 2000) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waits++;
         n++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         chk("accept timeout", 80'(in_ready), 80'd1);
      end else begin
         accepted++;
         if (s == 16'h0) begin
            e.data = cw[63:0];
            e.status = 2'b00;
            exp_q.push_back(e);
         end else begin
            p.cw = cw; p.syn = s; p.kind = kind; p.dly = dly; p.unc = unc; p.dd = dd;
            pln_q.push_back(p);
            if (kind == 0) begin
               e.data = dd;
               e.status = unc ? 2'b10 : 2'b01;
               exp_q.push_back(e);
            end else if (kind == 1) begin
               e.data = cw[63:0];
               e.status = 2'b11;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid || dec_req) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) chk("drain timeout", 80'(exp_q.size()), 80'd0);
   endtask

   // Consumer backpressure: tied high, random, tied low, or left to the main sequence.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: out_ready = 1'b0;
            default: ;
         endcase
      end
   end

   // Decoder model: checks each request against its plan, then acks, times out or aborts.
   initial begin
      plan_t p;
      int    n;
      forever begin
         @(posedge clk);
         #1;
         if (dec_req && !rst) begin
            if (pln_q.size() == 0) begin
               chk("unexpected dec_req", 80'(dec_req), 80'd0);
               p.kind = 2;
            end else begin
               p = pln_q.pop_front();
               chk("dec_codeword", dec_codeword, p.cw);
               chk("dec_syndrome", 80'(dec_syndrome), 80'(p.syn));
               chk("in_ready in decode", 80'(in_ready), 80'd0);
            end
            if (p.kind == 0) begin
               repeat (p.dly) begin
                  @(posedge clk);
                  #1;
               end
               chk("dec_req before ack", 80'(dec_req), 80'd1);
               dec_ack    = 1'b1;
               dec_uncorr = p.unc;
               dec_data   = p.dd;
               @(posedge clk);
               #1;
               dec_ack    = 1'b0;
               dec_uncorr = 1'($urandom_range(0, 1));
               dec_data   = {$urandom(), $urandom()};
               chk("dec_req after ack", 80'(dec_req), 80'd0);
            end else begin
               n = 0;
               while (dec_req && n < 400) begin
                  n++;
                  @(posedge clk);
                  #1;
               end
               if (p.kind == 1) begin
                  chk("timeout length", 80'(n), 80'(DEC_TIMEOUT));
                  // Late ack after the timeout must be ignored.
                  dec_ack  = 1'b1;
                  dec_data = {$urandom(), $urandom()};
                  @(posedge clk);
                  #1;
                  dec_ack  = 1'b0;
               end
            end
         end
      end
   end

   // Scoreboard monitor: output handshakes, stall stability, ready rules, counters.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_ce       = 0;
         m_due      = 0;
         prev_stall = 1'b0;
      end else begin
         chk("ce_count", 80'(ce_count), 80'(m_ce));
         chk("due_count", 80'(due_count), 80'(m_due));
         if (prev_stall) begin
            chk("stall out_valid", 80'(out_valid), 80'd1);
            chk("stall out_data", 80'(out_data), 80'(prev_data));
            chk("stall out_status", 80'(out_status), 80'(prev_status));
         end
         outst = accepted - fired;
         if (outst == 0) chk("in_ready idle", 80'(in_ready), 80'd1);
         if (out_valid && !out_ready && outst >= 2) chk("in_ready stalled", 80'(in_ready), 80'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected output", 80'(out_valid), 80'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_data", 80'(out_data), 80'(mon_e.data));
               chk("out_status", 80'(out_status), 80'(mon_e.status));
               if (!clr_counters) begin
                  if (mon_e.status == 2'b01 && m_ce < CNT_MAX) m_ce++;
                  if (mon_e.status[1] && m_due < CNT_MAX) m_due++;
               end
            end
            fired++;
            fire_cycles.push_back(cyc);
         end
         if (clr_counters) begin
            m_ce  = 0;
            m_due = 0;
         end
         prev_stall  = out_valid && !out_ready;
         prev_data   = out_data;
         prev_status = out_status;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [79:0] cw;
      logic [63:0] d;
      int          waits;
      int          kind;
      int          dly;
      logic        unc;
      logic [63:0] dd;
      int          n;

      // Reset held three cycles: every output at its reset value.
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 80'(in_ready), 80'd0);
      chk("rst out_valid", 80'(out_valid), 80'd0);
      chk("rst out_data", 80'(out_data), 80'd0);
      chk("rst out_status", 80'(out_status), 80'd0);
      chk("rst dec_req", 80'(dec_req), 80'd0);
      chk("rst dec_codeword", dec_codeword, 80'd0);
      chk("rst dec_syndrome", 80'(dec_syndrome), 80'd0);
      chk("rst ce_count", 80'(ce_count), 80'd0);
      chk("rst due_count", 80'(due_count), 80'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready after rst", 80'(in_ready), 80'd1);
      @(posedge clk);
      #1;

      // Single clean word: out_valid appears one edge after the accepting edge.
      send(80'h0, 0, 0, 1'b0, 64'h0, waits);
      chk("clean latency E0", 80'(out_valid), 80'd0);
      @(posedge clk);
      #1;
      chk("clean latency E1", 80'(out_valid), 80'd1);
      wait_drain();

      // Four back-to-back clean words at full throughput.
      fire_cycles.delete();
      for (int i = 0; i < 4; i++) begin
         send(80'h0, 0, 0, 1'b0, 64'h0, waits);
         chk("stream in_ready held", 80'(waits), 80'd0);
      end
      wait_drain();
      chk("stream output count", 80'(fire_cycles.size()), 80'd4);
      if (fire_cycles.size() == 4) begin
         chk("stream consecutive", 80'(fire_cycles[3] - fire_cycles[0]), 80'd3);
      end

      // Same stream with the consumer stalled for three cycles.
      rdy_mode  = 3;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(clean_cw({$urandom(), $urandom()}), 0, 0, 1'b0, 64'h0, waits);
            end
         end
         begin
            repeat (3) begin
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      rdy_mode = 0;
      wait_drain();

      // Correctable error on parity bit 79, acked five cycles later.
      cw     = '0;
      cw[79] = 1'b1;
      send(cw, 0, 5, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, waits);
      chk("dec_req at accept edge", 80'(dec_req), 80'd0);
      @(posedge clk);
      #1;
      chk("dec_req next edge", 80'(dec_req), 80'd1);
      wait_drain();
      chk("ce after CE", 80'(ce_count), 80'd1);

      // Uncorrectable (bits 79 and 61), then the same word timing out.
      cw[61] = 1'b1;
      send(cw, 0, 3, 1'b1, 64'h0123_4567_89AB_CDEF, waits);
      wait_drain();
      chk("due after DUE", 80'(due_count), 80'd1);
      send(cw, 1, 0, 1'b0, 64'h0, waits);
      wait_drain();
      chk("due after TIMEOUT", 80'(due_count), 80'd2);

      // Ack in the final timer cycle wins over the timeout.
      send(cw, 0, DEC_TIMEOUT - 1, 1'b1, 64'hFEED_FACE_0000_1111, waits);
      wait_drain();
      chk("due after last-cycle ack", 80'(due_count), 80'd3);

      // Clear in the same cycle as a CE handshake leaves ce_count at zero.
      rdy_mode  = 3;
      out_ready = 1'b0;
      cw        = '0;
      cw[79]    = 1'b1;
      send(cw, 0, 2, 1'b0, 64'h5A5A_5A5A_5A5A_5A5A, waits);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("CE output before clear", 80'(out_valid), 80'd1);
      out_ready    = 1'b1;
      clr_counters = 1'b1;
      @(posedge clk);
      #1;
      clr_counters = 1'b0;
      chk("clr wins over CE", 80'(ce_count), 80'd0);
      chk("clr due_count", 80'(due_count), 80'd0);
      rdy_mode = 0;
      wait_drain();

      // Random traffic with random backpressure; small counters reach saturation.
      rdy_mode = 1;
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         if ($urandom_range(0, 60) == 0) begin
            clr_counters = 1'b1;
            @(posedge clk);
            #1;
            clr_counters = 1'b0;
         end
         d    = {$urandom(), $urandom()};
         cw   = clean_cw(d);
         kind = 0;
         dly  = 0;
         unc  = 1'b0;
         dd   = '0;
         if ($urandom_range(0, 2) == 0) begin
            cw   = cw ^ (80'd1 << $urandom_range(0, 79));
            kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
            dly  = ($urandom_range(0, 5) == 0) ? DEC_TIMEOUT - 1 : $urandom_range(0, 30);
            unc  = ($urandom_range(0, 3) == 0);
            dd   = {$urandom(), $urandom()};
         end
         send(cw, kind, dly, unc, dd, waits);
      end
      rdy_mode = 0;
      wait_drain();

      // Reset during DEC_WAIT drops the pending word with no output.
      cw     = '0;
      cw[79] = 1'b1;
      send(cw, 2, 0, 1'b0, 64'h0, waits);
      n = 0;
      while (!dec_req && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("dec_req before rst", 80'(dec_req), 80'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("dec_req after rst", 80'(dec_req), 80'd0);
      exp_q.delete();
      accepted = 0;
      fired    = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      chk("no output after rst", 80'(out_valid), 80'd0);
      chk("ce_count after rst", 80'(ce_count), 80'd0);
      chk("due_count after rst", 80'(due_count), 80'd0);
      chk("plans consumed", 80'(pln_q.size()), 80'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
